// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: queues ALU commands in a small FIFO, issues them one at a
// time to an external combinational ALU, waits a fixed settle time, then
// captures and holds the result until the downstream side accepts it.
//
// Handshakes: both the command port (cmd_valid/cmd_ready) and the result
// port (res_valid/res_ready) transfer on a rising edge where valid and ready
// are both 1. A producer holds valid and its payload stable until that edge.
// cmd_ready depends only on the registered queue depth, never on a pop in
// the same cycle.
module alu_cmd_issue #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [2:0] cmd_code,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_code,
    input  logic [7:0] alu_out,
    input  logic       alu_swap,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_swap,
    output logic [2:0] res_code,
    output logic       res_err,
    output logic [4:0] fifo_count,
    output logic [1:0] dbg_state
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [18:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [4:0]      count;
    logic [18:0]     head;
    logic            nonempty;
    logic            push;
    logic            load;
    logic            capture;
    logic            release_res;
    logic [3:0]      settle_cnt;

    assign head       = mem[rd_ptr];
    assign nonempty   = (count != 5'd0);
    assign cmd_ready  = (count < 5'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign fifo_count = count;
    assign dbg_state  = state;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic; the pop decision uses the registered count, so a
    // command pushed into an empty queue is never popped on the same edge.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (nonempty) state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == 4'd0) state_nxt = ST_HOLD;
            ST_HOLD:   if (res_ready) state_nxt = nonempty ? ST_SETTLE : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: load pops the head into the ALU registers, capture latches
    // the ALU result, release_res ends a held result.
    always_comb begin
        load        = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            ST_IDLE:   load = nonempty;
            ST_SETTLE: capture = (settle_cnt == 4'd0);
            ST_HOLD: begin
                release_res = res_ready;
                load        = res_ready && nonempty;
            end
            default: ;
        endcase
    end

    // Queue storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_code, cmd_a, cmd_b};
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            case ({push, load})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // Settle counter: loaded on issue, counts down to the capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= 4'd0;
        end else if (load) begin
            settle_cnt <= 4'(SETTLE - 1);
        end else if (state == ST_SETTLE && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // ALU operand registers change only when a command is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= 8'd0;
            alu_b    <= 8'd0;
            alu_code <= 3'd0;
        end else if (load) begin
            alu_code <= head[18:16];
            alu_a    <= head[15:8];
            alu_b    <= head[7:0];
        end
    end

    // Result registers: invalid codes (4..7) report zero data with err set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= 8'd0;
            res_swap  <= 1'b0;
            res_code  <= 3'd0;
            res_err   <= 1'b0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_code  <= alu_code;
            if (alu_code[2]) begin
                res_data <= 8'd0;
                res_swap <= 1'b0;
                res_err  <= 1'b1;
            end else begin
                res_data <= alu_out;
                res_swap <= alu_swap;
                res_err  <= 1'b0;
            end
        end else if (release_res) begin
            res_valid <= 1'b0;
        end
    end

endmodule
